// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter merging N valid/ready streams into one registered output slice,
// holding the grant on one requester until its packet's last beat.
//   state  | meaning
//   IDLE   | no packet in progress, rotating search from ptr picks the winner
//   LOCKED | packet in progress, only requester own may transfer
module rr_stream_arbiter #(
  parameter int N  = 4,
  parameter int L  = 8,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   s_valid,
  output logic [N-1:0]   s_ready,
  input  logic [N*L-1:0] s_data,
  input  logic [N-1:0]   s_last,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [L-1:0]   m_data,
  output logic           m_last,
  output logic [SW-1:0]  m_src,
  output logic           busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state;
  logic [SW-1:0] ptr;
  logic [SW-1:0] own;
  logic [SW-1:0] g;
  logic          found;
  logic          load;
  logic          xfer;
  logic [L-1:0]  sel_data;
  logic          sel_last;
  int            idx;

  assign load = ~m_valid | m_ready;
  assign busy = (state == LOCKED) | m_valid;
  assign xfer = |(s_valid & s_ready);

  // Winner selection: owner when locked, else first valid from ptr upward with wrap.
  always_comb begin
    found = 1'b0;
    g     = ptr;
    idx   = 0;
    if (state == LOCKED) begin
      found = 1'b1;
      g     = own;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        for (int j = 0; j < N; j++) begin
          if (!found && (j == idx) && s_valid[j]) begin
            found = 1'b1;
            g     = SW'(j);
          end
        end
      end
    end
  end

  // Ready is driven from handshake state only; data and last merely follow the grant.
  always_comb begin
    s_ready  = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (SW'(j) == g) begin
        s_ready[j] = rst & found & load;
        sel_data   = s_data[j*L +: L];
        sel_last   = s_last[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      own     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_src   <= '0;
    end else begin
      if (load) begin
        m_valid <= xfer;
        if (xfer) begin
          m_data <= sel_data;
          m_last <= sel_last;
          m_src  <= g;
        end
      end
      if (xfer) begin
        if (sel_last) begin
          state <= IDLE;
          ptr   <= (g == SW'(N - 1)) ? '0 : g + SW'(1);
        end else if (state == IDLE) begin
          state <= LOCKED;
          own   <= g;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter (N=4, L=8) with hand-computed expectations.
`timescale 1ns/100ps
module tb_rr_stream_arbiter;

  localparam int N  = 4;
  localparam int L  = 8;
  localparam int SW = 2;

  logic          clk;
  logic          rst;
  logic [N-1:0]  s_valid;
  logic [N-1:0]  s_ready;
  logic [N*L-1:0] s_data;
  logic [N-1:0]  s_last;
  logic          m_valid;
  logic          m_ready;
  logic [L-1:0]  m_data;
  logic          m_last;
  logic [SW-1:0] m_src;
  logic          busy;

  int total = 0;
  int bad   = 0;

  rr_stream_arbiter #(.N(N), .L(L)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_src(m_src), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lane(input int i, input logic [7:0] d, input logic last);
    s_data[i*L +: L] = d;
    s_last[i]        = last;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic last, input logic [1:0] src);
    chk({tag, ".m_valid"}, m_valid, v);
    chk({tag, ".m_data"},  m_data,  d);
    chk({tag, ".m_last"},  m_last,  last);
    chk({tag, ".m_src"},   m_src,   src);
  endtask

  initial begin
    rst     = 1'b0;
    s_valid = 4'hF;
    s_data  = '0;
    s_last  = '0;
    m_ready = 1'b1;
    #12;
    chk_out("reset", 1'b0, 8'h00, 1'b0, 2'd0);
    chk("reset.busy", busy, 1'b0);
    chk("reset.s_ready", s_ready, 4'h0);
    s_valid = 4'h0;
    rst     = 1'b1;
    tick();

    // single beat from requester 2
    lane(2, 8'hA5, 1'b1);
    s_valid = 4'b0100;
    #1 chk("single.s_ready", s_ready, 4'b0100);
    tick();
    s_valid = 4'h0;
    chk_out("single", 1'b1, 8'hA5, 1'b1, 2'd2);
    chk("single.busy", busy, 1'b1);
    tick();
    chk_out("single.drain", 1'b0, 8'hA5, 1'b1, 2'd2);
    chk("single.busy_fall", busy, 1'b0);

    // all requesters valid; ptr=3 after previous packet, so 3 wins over 0
    for (int i = 0; i < N; i++) lane(i, 8'h10 + 8'(i), 1'b1);
    s_valid = 4'hF;
    #1 chk("rr.ptr3_ready", s_ready, 4'b1000);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out($sformatf("rr.beat%0d", i), 1'b1, 8'h10 + 8'((3 + i) % 4), 1'b1, 2'((3 + i) % 4));
    end
    s_valid = 4'h0;
    tick();
    chk("rr.idle_valid", m_valid, 1'b0);

    // 3-beat packet from requester 1 while requester 0 waits (ptr=1)
    lane(0, 8'h77, 1'b1);
    lane(1, 8'h01, 1'b0);
    s_valid = 4'b0011;
    tick();
    chk_out("pkt.b1", 1'b1, 8'h01, 1'b0, 2'd1);
    lane(1, 8'h02, 1'b0);
    #1 chk("pkt.locked_ready", s_ready, 4'b0010);
    tick();
    chk_out("pkt.b2", 1'b1, 8'h02, 1'b0, 2'd1);
    lane(1, 8'h03, 1'b1);
    tick();
    chk_out("pkt.b3", 1'b1, 8'h03, 1'b1, 2'd1);
    s_valid = 4'b0001;
    #1 chk("pkt.req0_ready", s_ready, 4'b0001);
    tick();
    chk_out("pkt.req0", 1'b1, 8'h77, 1'b1, 2'd0);
    s_valid = 4'h0;
    tick();

    // backpressure: hold 0x3C for 5 cycles while requester 3 waits (ptr=1)
    m_ready = 1'b0;
    lane(2, 8'h3C, 1'b1);
    s_valid = 4'b0100;
    tick();
    chk_out("stall.load", 1'b1, 8'h3C, 1'b1, 2'd2);
    lane(3, 8'h4D, 1'b1);
    s_valid = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("stall.s_ready%0d", i), s_ready, 4'h0);
      tick();
      chk_out($sformatf("stall.hold%0d", i), 1'b1, 8'h3C, 1'b1, 2'd2);
    end
    m_ready = 1'b1;
    #1 chk("stall.release_ready", s_ready, 4'b1000);
    tick();
    chk_out("stall.next", 1'b1, 8'h4D, 1'b1, 2'd3);
    s_valid = 4'h0;
    tick();
    chk("stall.drain", m_valid, 1'b0);

    // owner 3 gaps for 2 cycles while requester 0 is valid (ptr=0)
    lane(3, 8'h31, 1'b0);
    s_valid = 4'b1000;
    tick();
    chk_out("gap.b1", 1'b1, 8'h31, 1'b0, 2'd3);
    s_valid = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      #1 chk($sformatf("gap.s_ready%0d", i), s_ready, 4'b1000);
      tick();
      chk($sformatf("gap.bubble%0d", i), m_valid, 1'b0);
      chk($sformatf("gap.busy%0d", i), busy, 1'b1);
    end
    lane(3, 8'h32, 1'b1);
    s_valid = 4'b1001;
    tick();
    chk_out("gap.b2", 1'b1, 8'h32, 1'b1, 2'd3);
    s_valid = 4'b0001;
    tick();
    chk_out("gap.req0", 1'b1, 8'h77, 1'b1, 2'd0);
    s_valid = 4'h0;
    tick();

    // reset while locked on requester 2 with a beat in the slice (ptr=1)
    lane(2, 8'h21, 1'b0);
    s_valid = 4'b0100;
    tick();
    chk_out("rst.pre", 1'b1, 8'h21, 1'b0, 2'd2);
    m_ready = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk_out("rst.mid", 1'b0, 8'h00, 1'b0, 2'd0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.s_ready", s_ready, 4'h0);
    lane(0, 8'h05, 1'b1);
    s_valid = 4'b0101;
    m_ready = 1'b1;
    rst     = 1'b1;
    #1 chk("rst.after_ready", s_ready, 4'b0001);
    tick();
    chk_out("rst.after", 1'b1, 8'h05, 1'b1, 2'd0);
    s_valid = 4'h0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
